// File: rtl/ppm_pkg.sv
// Shared constants for the PPM encoder: FSM state codes, line patterns, slot counts
// and the CRC-16/X-25 parameters with a byte-wide update helper.
package ppm_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_SOF  = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_CRC  = 3'd3;
    localparam state_t ST_EOF  = 3'd4;
    localparam state_t ST_GAP  = 3'd5;

    localparam logic [7:0] SOF_PATTERN = 8'b0111_1011;
    localparam logic [3:0] EOF_PATTERN = 4'b1101;

    localparam int unsigned SOF_SLOTS = 8;
    localparam int unsigned SYM_SLOTS = 8;
    localparam int unsigned EOF_SLOTS = 4;

    localparam logic [15:0] CRC_POLY   = 16'h8408;
    localparam logic [15:0] CRC_INIT   = 16'hFFFF;
    localparam logic [15:0] CRC_XOROUT = 16'hFFFF;

    // Reflected CRC: data enters at the LSB end, one bit per iteration.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/ppm_crc16.sv
// Byte-wide CRC-16/X-25 accumulator; clear has priority over enable.
module ppm_crc16
    import ppm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc16_byte(crc, data);
        end
    end

endmodule

// File: rtl/ppm_encoder.sv
// 1-of-4 PPM serial transmitter with a one-entry holding register.
// Define PPM_ENC_CRC_EN to append a CRC-16/X-25 trailer before EOF.
module ppm_encoder
    import ppm_pkg::*;
#(
    parameter int unsigned SLOT_CYCLES = 16,
    parameter int unsigned GAP_SLOTS   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] Din,
    input  logic       din_valid,
    input  logic       din_last,
    output logic       din_ready,
    output logic       Dout,
    output logic       busy,
    output logic       err_underrun
);

    localparam int unsigned CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned GW = (GAP_SLOTS > 1) ? $clog2(GAP_SLOTS) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_SLOTS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [2:0]    slot_q, slot_d;
    logic [2:0]    sym_q, sym_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   data_q, data_d;
    logic          last_q, last_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_last_q, hold_last_d;
    logic          hold_full_q, hold_full_d;
    logic          slot_end, load, err_d, dout_d;
    logic [1:0]    sym_val;

`ifdef PPM_ENC_CRC_EN
    logic [15:0] crc_val;

    ppm_crc16 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == ST_IDLE),
        .en    (load),
        .data  (hold_q),
        .crc   (crc_val)
    );
`endif

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        slot_d   = slot_q;
        sym_d    = sym_q;
        gap_d    = gap_q;
        data_d   = data_q;
        last_d   = last_q;
        err_d    = 1'b0;
        load     = 1'b0;
        slot_end = (cyc_q == CYC_LAST);

        if (state_q != ST_IDLE) begin
            cyc_d = slot_end ? '0 : cyc_q + 1'b1;
            if (slot_end) slot_d = slot_q + 3'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    state_d = ST_SOF;
                    cyc_d   = '0;
                    slot_d  = '0;
                end
            end
            ST_SOF: begin
                if (slot_end && slot_q == 3'(SOF_SLOTS - 1)) begin
                    state_d = ST_DATA;
                    sym_d   = '0;
                    load    = 1'b1;
                end
            end
            ST_DATA: begin
                if (slot_end && slot_q == 3'(SYM_SLOTS - 1)) begin
                    sym_d = sym_q + 3'd1;
                    if (sym_q == 3'd3) begin
                        sym_d = '0;
                        if (last_q) begin
`ifdef PPM_ENC_CRC_EN
                            state_d = ST_CRC;
                            data_d  = crc_val ^ CRC_XOROUT;
`else
                            state_d = ST_EOF;
`endif
                        end else if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_EOF;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            ST_CRC: begin
                if (slot_end && slot_q == 3'(SYM_SLOTS - 1)) begin
                    sym_d = sym_q + 3'd1;
                    if (sym_q == 3'd7) state_d = ST_EOF;
                end
            end
            ST_EOF: begin
                if (slot_end && slot_q == 3'(EOF_SLOTS - 1)) begin
                    state_d = ST_GAP;
                    slot_d  = '0;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (slot_end) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                        slot_d  = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            data_d = {8'h00, hold_q};
            last_d = hold_last_q;
        end
    end

    // Load consumes the old content; an accept on the same edge refills it.
    always_comb begin
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        if (load) hold_full_d = 1'b0;
        if (din_valid && !hold_full_q) begin
            hold_d      = Din;
            hold_last_d = din_last;
            hold_full_d = 1'b1;
        end
    end

    // Line level is computed from next-state so the registered output lines up with it.
    always_comb begin
        sym_val = data_d[{sym_d, 1'b0} +: 2];
        case (state_d)
            ST_SOF:          dout_d = SOF_PATTERN[~slot_d];
            ST_DATA, ST_CRC: dout_d = (slot_d != {sym_val, 1'b1});
            ST_EOF:          dout_d = EOF_PATTERN[~slot_d[1:0]];
            default:         dout_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cyc_q        <= '0;
            slot_q       <= '0;
            sym_q        <= '0;
            gap_q        <= '0;
            data_q       <= '0;
            last_q       <= 1'b0;
            hold_q       <= '0;
            hold_last_q  <= 1'b0;
            hold_full_q  <= 1'b0;
            Dout         <= 1'b1;
            err_underrun <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            slot_q       <= slot_d;
            sym_q        <= sym_d;
            gap_q        <= gap_d;
            data_q       <= data_d;
            last_q       <= last_d;
            hold_q       <= hold_d;
            hold_last_q  <= hold_last_d;
            hold_full_q  <= hold_full_d;
            Dout         <= dout_d;
            err_underrun <= err_d;
        end
    end

    assign din_ready = !hold_full_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ppm_encoder.sv
// Directed bench for ppm_encoder: one instance at 16 clocks/slot, one at 4 clocks/slot.
module tb_ppm_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din_a, din_b;
    logic       valid_a, valid_b, last_a, last_b;
    logic       ready_a, ready_b, dout_a, dout_b, busy_a, busy_b, err_a, err_b;

    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt_a = 0;
    int err_cnt_b = 0;
    int busy_sum, lows_sum, e0, n;

    always #5 clk = ~clk;

    ppm_encoder #(.SLOT_CYCLES(16), .GAP_SLOTS(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Din          (din_a),
        .din_valid    (valid_a),
        .din_last     (last_a),
        .din_ready    (ready_a),
        .Dout         (dout_a),
        .busy         (busy_a),
        .err_underrun (err_a)
    );

    ppm_encoder #(.SLOT_CYCLES(4), .GAP_SLOTS(2)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .Din          (din_b),
        .din_valid    (valid_b),
        .din_last     (last_b),
        .din_ready    (ready_b),
        .Dout         (dout_b),
        .busy         (busy_b),
        .err_underrun (err_b)
    );

    always @(negedge clk) begin
        if (err_a === 1'b1) err_cnt_a <= err_cnt_a + 1;
        if (err_b === 1'b1) err_cnt_b <= err_cnt_b + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Samples n slots from the first clock of a slot; each slot must hold one level.
    task automatic expect_slots(input bit sel, input int ns, input logic [127:0] exp,
                                input string tag);
        logic [127:0] bits;
        int unstable, cyc;
        logic v, first;
        cyc = sel ? 4 : 16;
        bits = '0;
        unstable = 0;
        first = 1'b1;
        for (int s = 0; s < ns; s++) begin
            for (int c = 0; c < cyc; c++) begin
                v = sel ? dout_b : dout_a;
                if (c == 0) first = v;
                else if (v !== first) unstable++;
                if (v === 1'b0) lows_sum++;
                if ((sel ? busy_b : busy_a) === 1'b1) busy_sum++;
                @(negedge clk);
            end
            bits = {bits[126:0], first};
        end
        check(tag, bits, exp);
        check({tag, "_stable"}, 128'(unstable), 128'(0));
    endtask

    // Offers a byte at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit sel, input logic [7:0] b, input logic l);
        int k;
        if (sel) begin din_b = b; last_b = l; valid_b = 1'b1; end
        else begin din_a = b; last_a = l; valid_a = 1'b1; end
        k = 0;
        while ((sel ? ready_b : ready_a) !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("send_ready", 128'(k < 5000), 128'(1));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_frame(input bit sel, input string tag);
        check({tag, "_pre_sof"}, 128'({sel ? busy_b : busy_a, sel ? dout_b : dout_a}),
              128'(2'b01));
        @(negedge clk);
        check({tag, "_sof_edge"}, 128'({sel ? busy_b : busy_a, sel ? dout_b : dout_a}),
              128'(2'b10));
    endtask

    task automatic wait_idle(input bit sel);
        int k;
        k = 0;
        while ((sel ? busy_b : busy_a) !== 1'b0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", 128'(k < 5000), 128'(1));
        repeat (2) @(negedge clk);
    endtask

`ifdef PPM_ENC_CRC_EN
    function automatic logic [31:0] exp_byte(input logic [7:0] b);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            case (b[2*i +: 2])
                2'd0: r[31-8*i -: 8] = 8'hBF;
                2'd1: r[31-8*i -: 8] = 8'hEF;
                2'd2: r[31-8*i -: 8] = 8'hFB;
                default: r[31-8*i -: 8] = 8'hFE;
            endcase
        end
        return r;
    endfunction
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        din_a = '0; valid_a = 1'b0; last_a = 1'b0;
        din_b = '0; valid_b = 1'b0; last_b = 1'b0;
        busy_sum = 0;
        lows_sum = 0;
        repeat (3) @(negedge clk);
        check("reset_a", 128'({dout_a, ready_a, busy_a, err_a}), 128'(4'b1100));
        check("reset_b", 128'({dout_b, ready_b, busy_b, err_b}), 128'(4'b1100));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifndef PPM_ENC_CRC_EN
        // Single byte 0x1B, last.
        e0 = err_cnt_a;
        send(0, 8'h1B, 1'b1);
        valid_a = 1'b0;
        start_frame(0, "t1");
        check("t1_hold_full", 128'(ready_a), 128'(0));
        busy_sum = 0;
        expect_slots(0, 8, 128'(8'h7B), "t1_sof");
        check("t1_ready_rise", 128'(ready_a), 128'(1));
        expect_slots(0, 32, 128'(32'hFEFBEFBF), "t1_data");
        expect_slots(0, 4, 128'(4'hD), "t1_eof");
        expect_slots(0, 2, 128'(2'b11), "t1_gap");
        check("t1_busy_clocks", 128'(busy_sum), 128'(736));
        check("t1_busy_fall", 128'(busy_a), 128'(0));
        check("t1_no_underrun", 128'(err_cnt_a - e0), 128'(0));
        wait_idle(0);

        // Streamed 0x00, 0xFF, 0xA5 with valid held.
        e0 = err_cnt_a;
        send(0, 8'h00, 1'b0);
        fork
            begin
                send(0, 8'hFF, 1'b0);
                send(0, 8'hA5, 1'b1);
                valid_a = 1'b0;
            end
            begin
                start_frame(0, "t2");
                expect_slots(0, 8, 128'(8'h7B), "t2_sof");
                expect_slots(0, 96, 128'(96'hBFBFBFBF_FEFEFEFE_EFEFFBFB), "t2_data");
                expect_slots(0, 4, 128'(4'hD), "t2_eof");
            end
        join
        wait_idle(0);
        check("t2_no_underrun", 128'(err_cnt_a - e0), 128'(0));

        // Underrun after 0x3C, then a late 0x01 during the gap.
        e0 = err_cnt_a;
        send(0, 8'h3C, 1'b0);
        valid_a = 1'b0;
        start_frame(0, "t3");
        expect_slots(0, 8, 128'(8'h7B), "t3_sof");
        expect_slots(0, 32, 128'(32'hBFFEFEBF), "t3_data");
        expect_slots(0, 4, 128'(4'hD), "t3_eof");
        check("t3_underrun_once", 128'(err_cnt_a - e0), 128'(1));
        send(0, 8'h01, 1'b1);
        valid_a = 1'b0;
        n = 0;
        while (dout_a === 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("t3_late_sof_delay", 128'(n), 128'(32));
        expect_slots(0, 8, 128'(8'h7B), "t3_sof2");
        expect_slots(0, 32, 128'(32'hEFBFBFBF), "t3_data2");
        expect_slots(0, 4, 128'(4'hD), "t3_eof2");
        wait_idle(0);
        check("t3_underrun_total", 128'(err_cnt_a - e0), 128'(1));

        // Reset in the low slot of symbol 2, with a byte still held.
        send(0, 8'hFF, 1'b0);
        fork
            begin
                send(0, 8'h0F, 1'b0);
                valid_a = 1'b0;
            end
            begin
                start_frame(0, "t4");
                expect_slots(0, 8, 128'(8'h7B), "t4_sof");
                expect_slots(0, 16, 128'(16'hFEFE), "t4_sym01");
            end
        join
        expect_slots(0, 7, 128'(7'h7F), "t4_sym2_head");
        repeat (2) @(negedge clk);
        check("t4_pre_rst", 128'({dout_a, ready_a}), 128'(2'b00));
        #2 rst_n = 1'b0;
        #1 check("t4_async_rst", 128'({dout_a, ready_a, busy_a}), 128'(3'b110));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_discarded", 128'({dout_a, busy_a}), 128'(2'b10));
        send(0, 8'h55, 1'b1);
        valid_a = 1'b0;
        start_frame(0, "t4b");
        expect_slots(0, 8, 128'(8'h7B), "t4_sof2");
        expect_slots(0, 32, 128'(32'hEFEFEFEF), "t4_data2");
        expect_slots(0, 4, 128'(4'hD), "t4_eof2");
        wait_idle(0);

        // Four clocks per slot, byte 0xE4.
        send(1, 8'hE4, 1'b1);
        valid_b = 1'b0;
        start_frame(1, "t5");
        expect_slots(1, 8, 128'(8'h7B), "t5_sof");
        lows_sum = 0;
        expect_slots(1, 32, 128'(32'hBFEFFBFE), "t5_data");
        check("t5_low_clocks", 128'(lows_sum), 128'(16));
        expect_slots(1, 4, 128'(4'hD), "t5_eof");
        wait_idle(1);
        check("t5_no_underrun", 128'(err_cnt_b), 128'(0));
`else
        // "123456789" followed by CRC bytes 0x6E, 0x90.
        send(0, 8'h31, 1'b0);
        fork
            begin
                for (int i = 1; i < 9; i++) send(0, 8'(8'h31 + i), i == 8);
                valid_a = 1'b0;
            end
            begin
                start_frame(0, "crc");
                busy_sum = 0;
                expect_slots(0, 8, 128'(8'h7B), "crc_sof");
                for (int i = 0; i < 9; i++)
                    expect_slots(0, 32, 128'(exp_byte(8'(8'h31 + i))), "crc_msg_byte");
                expect_slots(0, 32, 128'(exp_byte(8'h6E)), "crc_lo");
                expect_slots(0, 32, 128'(exp_byte(8'h90)), "crc_hi");
                expect_slots(0, 4, 128'(4'hD), "crc_eof");
                check("crc_frame_clocks", 128'(busy_sum), 128'(364 * 16));
            end
        join
        wait_idle(0);
        check("crc_no_underrun", 128'(err_cnt_a), 128'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
